pc_next_seq: RTL and testbench
==============================

Name: pc_next_seq

Overview:
- Next-PC sequencer that drives the PCin input of the program-counter register and reads back its PCout, closing the fetch loop from the other end.
- Selects the next instruction address from these sources: sequential increment, conditional branch, absolute jump, call/return via a small return-address stack (RAS), stall hold and halt.
- Redirects requested while stalled are held and applied on the first non-stalled cycle.
- Addresses are word-indexed, so sequential increment is +1.

Parameters:
PC_WIDTH, 6, address width; must match the PC register.
RAS_DEPTH, 4, return-address stack entries (power of 2, ≥2).

Ports:
clk  in  1  system clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
pc_cur  in  PC_WIDTH  current PC (PC register output)
stall  in  1  hold PC this cycle
branch_taken  in  1  conditional branch resolved taken
branch_off  in  PC_WIDTH  signed two's-complement word offset relative to pc_cur+1
jump  in  1  absolute jump request
call  in  1  jump-and-link request; target is jump_target
jump_target  in  PC_WIDTH  absolute target for jump/call
ret  in  1  return request; target is popped from RAS
halt  in  1  stop fetch until reset
pc_next  out  PC_WIDTH  combinational next PC to PC register input
redirect_pending  out  1  registered; a held redirect awaits stall release
ras_empty  out  1  registered; RAS holds 0 entries
ras_full  out  1  registered; RAS holds RAS_DEPTH entries
ras_underflow  out  1  sticky; ret was issued with RAS empty
halted  out  1  registered; FSM in HALT

Behaviour:
- Reset is synchronous and active-high (rst, sampled on rising clk).
  - While rst=1: pc_next=0. On the next edge: FSM←RUN, redirect_pending=0, RAS count=0, ras_empty=1, ras_full=0, ras_underflow=0, halted=0, pending target=0.
  - Reset mid-operation discards any pending redirect and all RAS contents.
- Arithmetic: all modulo 2^PC_WIDTH; no overflow flag.
  - seq = pc_cur+1
  - branch target = pc_cur+1+branch_off
- Request priority, same cycle: halt > ret > call > jump > branch_taken > seq.
  - The winning source's target is T. Lower requests are ignored and have no side effects.
  - call and ret together: ret wins, no push.
- RAS side effects:
  - Apply in the cycle the request is accepted, whether or not stall=1.
  - call pushes seq and sets T=jump_target.
  - ret pops the top entry, T=popped value.
  - ret with RAS empty: T=seq, ras_underflow←1 (sticky until rst), count stays 0.
  - Push when full: circular overwrite of the oldest entry; count stays RAS_DEPTH, ras_full stays 1.
  - Only winning call/ret touches the RAS.
- FSM states and transitions:
  - RUN
    - halt → pc_next=pc_cur, next state HALT.
    - Else stall=0 → pc_next=T.
    - Else stall=1 with a redirect (ret/call/jump/branch) → pc_next=pc_cur, latch T, next state PEND.
    - Else stall=1 with no redirect → pc_next=pc_cur.
  - PEND (redirect_pending=1)
    - halt → HALT, pending discarded.
    - Else stall=1 → pc_next=pc_cur. A new redirect overwrites the latched target (latest wins; RAS effects still apply).
    - Else stall=0 → pc_next = newly accepted redirect target if one is present this cycle, otherwise the latched target; next state RUN.
  - HALT: pc_next=pc_cur, halted=1, all requests ignored (no RAS change). Exit only via rst.
- Latency:
  - pc_next is combinational; redirect is 0-cycle.
  - PC register shows the target 1 edge later.
  - A held redirect appears on pc_next in the first cycle stall=0.

Test Plan:
- rst for 2 cycles, then pc_cur follows pc_next for 4 cycles → pc_next 0 under rst, then sequence 1,2,3,4; ras_empty=1, halted=0.
- Branch and wrap-around:
  - pc_cur=10, branch_taken, branch_off=6'h3E (−2) → pc_next=9.
  - pc_cur=63, no request → pc_next=0.
  - pc_cur=60, branch_off=5 → pc_next=2.
- call at pc_cur=5 with jump_target=20 → pc_next=20, ras_empty=0. Later ret at pc_cur=22 → pc_next=6, ras_empty=1.
- RAS overflow and underflow:
  - 5 calls from pc_cur=1,2,3,4,5 → ras_full=1.
  - 4 rets → return targets 6,5,4,3.
  - 5th ret → pc_next=pc_cur+1, ras_underflow=1.
- stall=1 for 3 cycles with pc_cur=8 and jump to 30 in the first stalled cycle:
  - pc_next=8 while stalled; redirect_pending=1.
  - On release, pc_next=30 and redirect_pending then clears.
  - Repeat with a second jump to 40 mid-stall → release gives 40.
- halt with simultaneous jump at pc_cur=12 → pc_next=12 forever, halted=1, later calls leave RAS unchanged. rst asserted mid-PEND → all flags cleared, pc_next=0.

Source files
------------

// File: rtl/pc_next_seq.sv
// Next-PC sequencer: picks the next fetch address (sequential, branch, jump,
// call/return through a small return-address stack, stall hold, halt) and
// drives it combinationally into the PC register.
module pc_next_seq #(
    parameter int PC_WIDTH  = 6,
    parameter int RAS_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [PC_WIDTH-1:0] pc_cur,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_off,
    input  logic                jump,
    input  logic                call,
    input  logic [PC_WIDTH-1:0] jump_target,
    input  logic                ret,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] pc_next,
    output logic                redirect_pending,
    output logic                ras_empty,
    output logic                ras_full,
    output logic                ras_underflow,
    output logic                halted
);

    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_PEND = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t              state_reg;
    logic [PC_WIDTH-1:0] pend_target_reg;
    logic                redirect_pending_reg;
    logic                halted_reg;

    // Return-address stack: circular buffer, top_reg is the next write slot.
    // Read is combinational because a return redirects in the same cycle.
    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PW-1:0]       top_reg, top_next;
    logic [CW-1:0]       count_reg, count_next;
    logic                ras_empty_reg, ras_full_reg, ras_underflow_reg;

    logic [PC_WIDTH-1:0] seq, branch_tgt, target;
    logic [PW-1:0]       pop_idx;
    logic                accept, ras_nonempty;
    logic                do_halt, do_ret, do_call, do_jump, do_branch, redirect;

    // Request arbitration and target selection (halt > ret > call > jump > branch > seq).
    always_comb begin
        seq          = pc_cur + PC_WIDTH'(1);
        branch_tgt   = seq + branch_off;
        accept       = (state_reg != ST_HALT) && !rst;
        do_halt      = accept && halt;
        do_ret       = accept && !halt && ret;
        do_call      = accept && !halt && !ret && call;
        do_jump      = accept && !halt && !ret && !call && jump;
        do_branch    = accept && !halt && !ret && !call && !jump && branch_taken;
        redirect     = do_ret || do_call || do_jump || do_branch;
        pop_idx      = top_reg - PW'(1);
        ras_nonempty = (count_reg != '0);
        target       = seq;
        if (do_ret) begin
            target = ras_nonempty ? ras_mem[pop_idx] : seq;
        end else if (do_call) begin
            target = jump_target;
        end else if (do_jump) begin
            target = jump_target;
        end else if (do_branch) begin
            target = branch_tgt;
        end
    end

    // Next PC: hold while stalled or halted, deliver a held redirect on release.
    always_comb begin
        pc_next = pc_cur;
        if (rst) begin
            pc_next = '0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (!do_halt && !stall) pc_next = target;
                end
                ST_PEND: begin
                    if (!do_halt && !stall) pc_next = redirect ? target : pend_target_reg;
                end
                default: pc_next = pc_cur;
            endcase
        end
    end

    // Stack pointer/occupancy update; a push on a full stack overwrites the oldest entry.
    always_comb begin
        top_next   = top_reg;
        count_next = count_reg;
        if (do_call) begin
            top_next = top_reg + PW'(1);
            if (count_reg != CW'(RAS_DEPTH)) count_next = count_reg + CW'(1);
        end else if (do_ret && ras_nonempty) begin
            top_next   = pop_idx;
            count_next = count_reg - CW'(1);
        end
    end

    // Sequencer FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg            <= ST_RUN;
            pend_target_reg      <= '0;
            redirect_pending_reg <= 1'b0;
            halted_reg           <= 1'b0;
        end else begin
            case (state_reg)
                ST_RUN: begin
                    if (do_halt) begin
                        state_reg  <= ST_HALT;
                        halted_reg <= 1'b1;
                    end else if (stall && redirect) begin
                        state_reg            <= ST_PEND;
                        pend_target_reg      <= target;
                        redirect_pending_reg <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (do_halt) begin
                        state_reg            <= ST_HALT;
                        halted_reg           <= 1'b1;
                        redirect_pending_reg <= 1'b0;
                    end else if (stall) begin
                        if (redirect) pend_target_reg <= target;
                    end else begin
                        state_reg            <= ST_RUN;
                        redirect_pending_reg <= 1'b0;
                    end
                end
                default: state_reg <= ST_HALT;
            endcase
        end
    end

    // Stack bookkeeping and flags; contents are discarded on reset by clearing the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            top_reg           <= '0;
            count_reg         <= '0;
            ras_empty_reg     <= 1'b1;
            ras_full_reg      <= 1'b0;
            ras_underflow_reg <= 1'b0;
        end else begin
            top_reg       <= top_next;
            count_reg     <= count_next;
            ras_empty_reg <= (count_next == '0);
            ras_full_reg  <= (count_next == CW'(RAS_DEPTH));
            if (do_ret && !ras_nonempty) ras_underflow_reg <= 1'b1;
        end
    end

    // Stack storage write on an accepted call.
    always_ff @(posedge clk) begin
        if (do_call) ras_mem[top_reg] <= seq;
    end

    assign redirect_pending = redirect_pending_reg;
    assign halted           = halted_reg;
    assign ras_empty        = ras_empty_reg;
    assign ras_full         = ras_full_reg;
    assign ras_underflow    = ras_underflow_reg;

endmodule

// File: tb/tb_pc_next_seq.sv
// Scoreboard bench for pc_next_seq: each driven cycle pushes the reference
// model's expected pc_next and status flags; a negedge monitor pops and compares.
module tb_pc_next_seq;

    localparam int W = 6;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] pc_cur = '0;
    logic         stall = 1'b0, branch_taken = 1'b0, jump = 1'b0, call = 1'b0;
    logic         ret = 1'b0, halt = 1'b0;
    logic [W-1:0] branch_off = '0, jump_target = '0;
    logic [W-1:0] pc_next;
    logic         redirect_pending, ras_empty, ras_full, ras_underflow, halted;

    pc_next_seq #(.PC_WIDTH(W), .RAS_DEPTH(D)) dut (
        .clk(clk), .rst(rst), .pc_cur(pc_cur), .stall(stall),
        .branch_taken(branch_taken), .branch_off(branch_off), .jump(jump),
        .call(call), .jump_target(jump_target), .ret(ret), .halt(halt),
        .pc_next(pc_next), .redirect_pending(redirect_pending),
        .ras_empty(ras_empty), .ras_full(ras_full),
        .ras_underflow(ras_underflow), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [W-1:0] pc;
        logic [4:0]   flags; // {redirect_pending, ras_empty, ras_full, ras_underflow, halted}
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn = 0;

    // Reference model state
    logic [W-1:0] ras_q[$];
    logic         m_pending = 1'b0, m_halted = 1'b0, m_underflow = 1'b0;
    logic [W-1:0] m_ptgt = '0;
    logic [W-1:0] last_exp = '0;

    task automatic model_reset();
        ras_q.delete();
        m_pending = 1'b0; m_halted = 1'b0; m_underflow = 1'b0; m_ptgt = '0;
    endtask

    // One clock cycle of stimulus; expected values come from the model.
    task automatic cyc(input logic r, input logic [W-1:0] pc, input logic s,
                       input logic h, input logic rt, input logic cl,
                       input logic jp, input logic br,
                       input logic [W-1:0] tgt, input logic [W-1:0] off);
        exp_t         e;
        logic [W-1:0] seqv, t, pcx;
        logic         redir;
        @(posedge clk);
        #1;
        rst = r; pc_cur = pc; stall = s; halt = h; ret = rt; call = cl;
        jump = jp; branch_taken = br; jump_target = tgt; branch_off = off;
        e.id    = txn;
        e.flags = {m_pending, (ras_q.size() == 0), (ras_q.size() == D), m_underflow, m_halted};
        seqv  = pc + W'(1);
        pcx   = pc;
        redir = 1'b0;
        t     = seqv;
        if (r) begin
            pcx = '0;
            model_reset();
        end else if (m_halted) begin
            pcx = pc;
        end else if (h) begin
            m_halted = 1'b1; m_pending = 1'b0;
        end else begin
            redir = rt | cl | jp | br;
            if (rt) begin
                if (ras_q.size() > 0) t = ras_q.pop_back();
                else m_underflow = 1'b1;
            end else if (cl) begin
                ras_q.push_back(seqv);
                if (ras_q.size() > D) void'(ras_q.pop_front());
                t = tgt;
            end else if (jp) begin
                t = tgt;
            end else if (br) begin
                t = seqv + off;
            end
            if (!m_pending) begin
                if (!s) pcx = t;
                else if (redir) begin m_pending = 1'b1; m_ptgt = t; end
            end else begin
                if (s) begin
                    if (redir) m_ptgt = t;
                end else begin
                    pcx = redir ? t : m_ptgt;
                    m_pending = 1'b0;
                end
            end
        end
        e.pc = pcx;
        last_exp = pcx;
        exp_q.push_back(e);
        txn++;
    endtask

    task automatic idle(input logic [W-1:0] pc);
        cyc(1'b0, pc, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    // Monitor: compare DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [4:0] got;
            e = exp_q.pop_front();
            got = {redirect_pending, ras_empty, ras_full, ras_underflow, halted};
            checks++;
            if (pc_next !== e.pc) begin
                errors++;
                $display("FAIL txn %0d pc_next got %0d expected %0d", e.id, pc_next, e.pc);
            end
            checks++;
            if (got !== e.flags) begin
                errors++;
                $display("FAIL txn %0d flags{pend,empty,full,uflow,halted} got %b expected %b",
                         e.id, got, e.flags);
            end
        end
    end

    initial begin
        // Initial reset before any checking
        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset for 2 cycles, then pc_cur follows pc_next: 1,2,3,4
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) idle(last_exp);

        // Branch and wrap-around
        cyc(0, 10, 0, 0, 0, 0, 0, 1, 0, 6'h3E);
        idle(63);
        cyc(0, 60, 0, 0, 0, 0, 0, 1, 0, 5);

        // Call then return
        cyc(0, 5, 0, 0, 0, 1, 0, 0, 20, 0);
        idle(20);
        cyc(0, 22, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(6);

        // Overflow and underflow of the RAS
        for (int i = 1; i <= 5; i++) cyc(0, W'(i), 0, 0, 0, 1, 0, 0, 40, 0);
        for (int i = 0; i < 5; i++) cyc(0, 33, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(7);

        // Stall with a jump in the first stalled cycle
        cyc(0, 8, 1, 0, 0, 0, 1, 0, 30, 0);
        cyc(0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(8);
        idle(30);
        // Second jump mid-stall overrides the first
        cyc(0, 8, 1, 0, 0, 0, 1, 0, 30, 0);
        cyc(0, 8, 1, 0, 0, 0, 1, 0, 40, 0);
        cyc(0, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(8);
        idle(40);

        // Reset while a redirect is pending
        cyc(0, 8, 1, 0, 0, 1, 0, 0, 50, 0);
        cyc(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0);

        // Halt wins over a simultaneous jump; later requests ignored
        cyc(0, 12, 0, 1, 0, 0, 1, 0, 30, 0);
        for (int i = 0; i < 3; i++) cyc(0, 12, 0, 0, 0, 1, 0, 0, 25, 0);
        cyc(0, 12, 0, 0, 1, 0, 0, 0, 0, 0);
        cyc(1, 12, 0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            logic r, s, h, rt, cl, jp, br;
            r  = ($urandom_range(0, 99) < 2) || (m_halted && $urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 99) < 35);
            h  = ($urandom_range(0, 99) < 2);
            rt = ($urandom_range(0, 99) < 20);
            cl = ($urandom_range(0, 99) < 25);
            jp = ($urandom_range(0, 99) < 20);
            br = ($urandom_range(0, 99) < 25);
            cyc(r, W'($urandom), s, h, rt, cl, jp, br, W'($urandom), W'($urandom));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain queue got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
